mod_addsub_seq: RTL and testbench

- Limb-serial modular adder/subtractor for the crypto datapath.
- Computes R = (X + Y) mod M or R = (X − Y) mod M, with operands up to LIMB_W*LIMBS bits.
- Drives the team's combinational ripple adder n_adder_verilog one limb per cycle and chains the carry between limbs in a register.
- Runs two passes: a raw add/sub, then a conditional correction by M. It feeds the modular exponentiation / Montgomery control.

---
 rtl/mod_arith_pkg.sv | 28 ++
 rtl/n_adder_verilog.sv | 36 +++
 rtl/mod_addsub_seq.sv | 163 ++++++++++++++++
 tb/tb_mod_addsub_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_arith_pkg
//  Description : Shared definitions for the limb-serial modular arithmetic
//                blocks: FSM state encoding, default limb geometry and the
//                operation select constants.
//  Revision    : 1.0  initial release
// ============================================================================
package mod_arith_pkg;

  // Default limb geometry: 4 limbs of 16 bits -> 64-bit operands
  localparam int DEF_LIMB_W = 16;
  localparam int DEF_LIMBS  = 4;

  // Operation select values carried on op_sub
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    FIN  = 2'd3
  } addsub_state_t;

endpackage : mod_arith_pkg
`default_nettype wire

// File: rtl/n_adder_verilog.sv
`default_nettype none
// ============================================================================
//  Module      : n_adder_verilog
//  Description : N-bit combinational ripple-carry adder. SUM = A + B + CIN,
//                truncated to N bits; callers wanting a carry-out zero-extend
//                their operands by one bit and read the top SUM bit.
//  Ports       : A, B  [N-1:0] in   addends
//                CIN           in   carry into bit 0
//                SUM   [N-1:0] out  sum (no separate carry-out)
//  Revision    : 1.0  initial release
// ============================================================================
module n_adder_verilog #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic [N-1:0] SUM
);

  // w_c[i] is the carry into bit i; no carry leaves the top bit
  logic [N-1:0] w_c;

  assign w_c[0] = CIN;

  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign SUM[i] = A[i] ^ B[i] ^ w_c[i];
      if (i < N - 1) begin : g_carry
        assign w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
      end
    end
  endgenerate

endmodule : n_adder_verilog
`default_nettype wire

// File: rtl/mod_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mod_addsub_seq
//  Description : Limb-serial modular adder/subtractor. R = (X +/- Y) mod M,
//                computed one limb per cycle through a single ripple adder.
//                Pass 1 forms S = X +/- Y, pass 2 forms T = S -/+ M, and the
//                final cycle picks S or T from the two pass carries.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                start, op_sub      request (IDLE only) and add/sub select
//                x, y, m   [W-1:0]  operands (X,Y < M) and modulus (M > 0)
//                busy               operation in progress
//                done               one-cycle pulse, result valid from here
//                result    [W-1:0]  R, held until the next done or rst
//  Revision    : 1.0  initial release
// ============================================================================
module mod_addsub_seq
  import mod_arith_pkg::*;
#(
  parameter int LIMB_W = DEF_LIMB_W,
  parameter int LIMBS  = DEF_LIMBS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op_sub,
  input  logic [LIMB_W*LIMBS-1:0] x,
  input  logic [LIMB_W*LIMBS-1:0] y,
  input  logic [LIMB_W*LIMBS-1:0] m,
  output logic                    busy,
  output logic                    done,
  output logic [LIMB_W*LIMBS-1:0] result
);

  localparam int W     = LIMB_W * LIMBS;
  localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  addsub_state_t r_state, w_state_next;

  logic [IDX_W-1:0] r_idx;
  logic             r_carry, r_c1, r_c2, r_sub;
  logic             r_busy, r_done;
  logic [W-1:0]     r_x, r_y, r_m, r_s, r_t, r_result;

  logic              w_last;
  logic [LIMB_W-1:0] w_x_limb, w_y_limb, w_m_limb, w_s_limb;
  logic [LIMB_W-1:0] w_a_limb, w_b_limb;
  logic [LIMB_W:0]   w_sum;

  assign w_last   = (r_idx == IDX_W'(LIMBS - 1));
  assign w_x_limb = r_x[r_idx*LIMB_W +: LIMB_W];
  assign w_y_limb = r_y[r_idx*LIMB_W +: LIMB_W];
  assign w_m_limb = r_m[r_idx*LIMB_W +: LIMB_W];
  assign w_s_limb = r_s[r_idx*LIMB_W +: LIMB_W];

  // Pass 1: X + Y (carry 0) or X + ~Y + 1.
  // Pass 2: S + ~M + 1 for add (trial subtract), S + M for sub (borrow fix).
  always_comb begin
    w_a_limb = w_x_limb;
    w_b_limb = (r_sub == OP_SUB) ? ~w_y_limb : w_y_limb;
    if (r_state == P2) begin
      w_a_limb = w_s_limb;
      w_b_limb = (r_sub == OP_SUB) ? w_m_limb : ~w_m_limb;
    end
  end

  n_adder_verilog #(
    .N (LIMB_W + 1)
  ) u_adder (
    .A   ({1'b0, w_a_limb}),
    .B   ({1'b0, w_b_limb}),
    .CIN (r_carry),
    .SUM (w_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = P1;
      P1:      if (w_last) w_state_next = P2;
      P2:      if (w_last) w_state_next = FIN;
      FIN:                 w_state_next = IDLE;
      default:             w_state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_c1     <= 1'b0;
      r_c2     <= 1'b0;
      r_sub    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_m      <= '0;
      r_s      <= '0;
      r_t      <= '0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      // Busy covers the P1/P2 cycles as seen one edge later, so it drops in
      // the same cycle done rises.
      r_busy <= (r_state == P1) || (r_state == P2);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_m     <= m;
            r_sub   <= op_sub;
            r_carry <= op_sub;  // +1 completes the two's complement of Y
            r_idx   <= '0;
          end
        end
        P1: begin
          r_s[r_idx*LIMB_W +: LIMB_W] <= w_sum[LIMB_W-1:0];
          if (w_last) begin
            r_c1    <= w_sum[LIMB_W];
            r_carry <= ~r_sub;
            r_idx   <= '0;
          end else begin
            r_carry <= w_sum[LIMB_W];
            r_idx   <= r_idx + 1'b1;
          end
        end
        P2: begin
          r_t[r_idx*LIMB_W +: LIMB_W] <= w_sum[LIMB_W-1:0];
          if (w_last) begin
            r_c2  <= w_sum[LIMB_W];
            r_idx <= '0;
          end else begin
            r_carry <= w_sum[LIMB_W];
            r_idx   <= r_idx + 1'b1;
          end
        end
        FIN: begin
          // Add: subtract M if the raw sum overflowed or S >= M.
          // Sub: c1 = no borrow, so S is already in range; else use S + M.
          if (r_sub == OP_SUB) r_result <= r_c1 ? r_s : r_t;
          else                 r_result <= (r_c1 | r_c2) ? r_t : r_s;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule : mod_addsub_seq
`default_nettype wire

// File: tb/tb_mod_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_addsub_seq
//  Description : Self-checking bench for mod_addsub_seq (16-bit limbs x 4).
//                Table of directed vectors plus hand-written control cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod_addsub_seq;

  localparam logic [63:0] P = 64'hFFFF_FFFF_FFFF_FFC5;

  typedef struct {
    string       name;
    logic        sub;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] m;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [63:0] x, y, m;
  logic        busy, done;
  logic [63:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  mod_addsub_seq #(
    .LIMB_W (16),
    .LIMBS  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .x      (x),
    .y      (y),
    .m      (m),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation starting in the current cycle; returns after the
  // sample in which done is seen (or after the cycle budget runs out).
  task automatic run_op(input logic s, input logic [63:0] xv, input logic [63:0] yv,
                        input logic [63:0] mv, output int lat, output int busy_cnt);
    start  = 1'b1;
    op_sub = s;
    x      = xv;
    y      = yv;
    m      = mv;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  vec_t vecs[10];
  int   lat, bcnt, dcnt;

  initial begin
    vecs[0] = '{"small_add",     1'b0, 64'd3,                 64'd5,                 64'd7, 64'd1};
    vecs[1] = '{"fullwidth_add", 1'b0, 64'hFFFFFFFFFFFFFFC4, 64'hFFFFFFFFFFFFFFC4, P,     64'hFFFFFFFFFFFFFFC3};
    vecs[2] = '{"sub_borrow",    1'b1, 64'd1,                 64'd2,                 P,     64'hFFFFFFFFFFFFFFC4};
    vecs[3] = '{"limb_carry",    1'b0, 64'h000000000000FFFF, 64'd1,                 P,     64'h0000000000010000};
    vecs[4] = '{"exact_sum",     1'b0, 64'd8,                 64'hFFFFFFFFFFFFFFBD, P,     64'd0};
    vecs[5] = '{"sub_equal",     1'b1, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, P,     64'd0};
    vecs[6] = '{"sub_small",     1'b1, 64'd5,                 64'd3,                 64'd7, 64'd2};
    vecs[7] = '{"add_wrap7",     1'b0, 64'd6,                 64'd6,                 64'd7, 64'd5};
    vecs[8] = '{"sub_zero_x",    1'b1, 64'd0,                 64'hFFFFFFFFFFFFFFC4, P,     64'd1};
    vecs[9] = '{"mod_one",       1'b0, 64'd0,                 64'd0,                 64'd1, 64'd0};

    rst = 1'b1; start = 1'b0; op_sub = 1'b0; x = '0; y = '0; m = '0;
    repeat (3) tick();
    check("reset_busy",   {63'd0, busy}, 64'd0);
    check("reset_done",   {63'd0, done}, 64'd0);
    check("reset_result", result,        64'd0);
    rst = 1'b0;
    tick();

    // Table vectors, each started in the done cycle of the previous one
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sub, vecs[i].x, vecs[i].y, vecs[i].m, lat, bcnt);
      check({vecs[i].name, "_result"}, result,        vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat),     64'd9);
      check({vecs[i].name, "_busy"},    64'(bcnt),    64'd8);
    end
    tick();
    check("done_single_pulse", {63'd0, done}, 64'd0);
    check("result_held",       result,        64'd0);

    // A second start while busy, with different operands, must be ignored
    start = 1'b1; op_sub = 1'b0; x = 64'd3; y = 64'd5; m = 64'd7;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      if (lat == 3) begin
        start = 1'b1; op_sub = 1'b1; x = 64'd6; y = 64'd1; m = 64'd11;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("ignore_start_result",  result,     64'd1);
    check("ignore_start_latency", 64'(lat),   64'd9);
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) dcnt++;
    end
    check("ignore_start_no_extra_done", 64'(dcnt), 64'd0);

    // Back-to-back: first start, then a second start in the done cycle
    run_op(1'b0, 64'd6, 64'd5, 64'd7, lat, bcnt);
    check("b2b_first_result", result, 64'd4);
    run_op(1'b1, 64'd2, 64'd6, 64'd7, lat, bcnt);
    check("b2b_second_result",  result,   64'd3);
    check("b2b_second_latency", 64'(lat), 64'd9);

    // Reset five cycles into an operation aborts it cleanly
    start = 1'b1; op_sub = 1'b0; x = 64'd1; y = 64'd1; m = 64'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",   {63'd0, busy}, 64'd0);
    check("abort_done",   {63'd0, done}, 64'd0);
    check("abort_result", result,        64'd0);
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    run_op(1'b0, 64'h000000000000FFFF, 64'd1, P, lat, bcnt);
    check("after_abort_result",  result,   64'h0000000000010000);
    check("after_abort_latency", 64'(lat), 64'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mod_addsub_seq
`default_nettype wire
